// File: rtl/microondas_pkg.sv
// Shared types and constants for the microwave keypad path.
// Latency: n/a (package only).
// Backpressure: n/a.
package microondas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EVAL    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } kp_state_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam int MAX_DIGITS = 4;

endpackage

// File: rtl/keypad_digit_decoder_bcd_to_7seg.sv
// BCD digit to 7-segment pattern; non-decimal values blank the digit.
// Latency: combinational.
// Backpressure: none.
module bcd_to_7seg
    import microondas_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/keypad_digit_decoder.sv
// Accepts one BCD digit per key press into an MM:SS shift register and drives 7-seg.
// Latency: digit stored / pulse reported one edge after key_valid is first sampled high.
// Backpressure: none; presses arriving while full or not permitted are consumed and reported rejected.
module keypad_digit_decoder
    import microondas_pkg::*;
#(
    parameter int HOLDOFF = 7
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       load_en,
    input  logic       entry_clr,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] digit_count,
    output logic       time_valid,
    output logic       accepted,
    output logic       rejected,
    output logic [6:0] seg_mt,
    output logic [6:0] seg_mo,
    output logic [6:0] seg_st,
    output logic [6:0] seg_so
);

    kp_state_t  state_q;
    logic [3:0] code_q;
    logic [3:0] hold_q;
    logic [3:0] hold_d;
    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [2:0] count_q;
    logic       accepted_q, rejected_q;
    logic       store_ok;

    assign hold_d   = hold_q - 4'd1;
    assign store_ok = load_en && (code_q <= 4'd9) && (count_q < 3'(MAX_DIGITS));

    // Press FSM, hold-off counter, entry shift register and digit counter
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            // Start in RELEASE so a key held through reset is never taken
            state_q    <= ST_RELEASE;
            code_q     <= 4'd0;
            hold_q     <= 4'd0;
            mt_q       <= 4'd0;
            mo_q       <= 4'd0;
            st_q       <= 4'd0;
            so_q       <= 4'd0;
            count_q    <= 3'd0;
            accepted_q <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            accepted_q <= 1'b0;
            rejected_q <= 1'b0;

            // Cancel key works in every state; in EVAL it also overrides the store
            if (entry_clr) begin
                mt_q    <= 4'd0;
                mo_q    <= 4'd0;
                st_q    <= 4'd0;
                so_q    <= 4'd0;
                count_q <= 3'd0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (key_valid) begin
                        code_q  <= key_code;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (store_ok && !entry_clr) begin
                        mt_q       <= mo_q;
                        mo_q       <= st_q;
                        st_q       <= so_q;
                        so_q       <= code_q;
                        count_q    <= count_q + 3'd1;
                        accepted_q <= 1'b1;
                    end else begin
                        rejected_q <= 1'b1;
                    end
                    hold_q  <= 4'(HOLDOFF);
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    // HOLDOFF cycles spent here, key_valid ignored
                    hold_q <= hold_d;
                    if (hold_d == 4'd0) begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!key_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_RELEASE;
            endcase
        end
    end

    assign min_tens    = mt_q;
    assign min_ones    = mo_q;
    assign sec_tens    = st_q;
    assign sec_ones    = so_q;
    assign digit_count = count_q;
    assign accepted    = accepted_q;
    assign rejected    = rejected_q;
    assign time_valid  = (count_q != 3'd0) && (st_q <= 4'd5);

    bcd_to_7seg u_seg_mt (.bcd_i(mt_q), .seg_o(seg_mt));
    bcd_to_7seg u_seg_mo (.bcd_i(mo_q), .seg_o(seg_mo));
    bcd_to_7seg u_seg_st (.bcd_i(st_q), .seg_o(seg_st));
    bcd_to_7seg u_seg_so (.bcd_i(so_q), .seg_o(seg_so));

endmodule

// File: doc/keypad_digit_decoder.md
# keypad_digit_decoder

Receiving end of the microwave keypad encoder. It consumes the encoder's 4-bit BCD key code and its delayed valid level, and accepts exactly one digit per key press with a hold-off window. Accepted digits shift right-to-left into a four-digit MM:SS entry register. All four digits are also driven as 7-segment patterns for the display.

## Interface
Parameters:
- HOLDOFF, 7: cycles ignored after an accepted key, on top of the release requirement; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clear_n  in  1  reset; synchronous, active-low.
- key_code  in  4  BCD code from the encoder; sampled only on a qualifying key_valid rise.
- key_valid  in  1  level from the encoder; high while a key is held, after the encoder's delay.
- load_en  in  1  entry permitted, e.g. oven idle; when low, presses are consumed but not stored.
- entry_clr  in  1  synchronous clear of the entry register (cancel key).
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  stored digits.
- digit_count  out  3  number of digits entered, 0..4.
- time_valid  out  1  high when digit_count != 0 and sec_tens <= 5.
- accepted  out  1  one-cycle pulse: a digit was stored.
- rejected  out  1  one-cycle pulse: a press was consumed without storing.
- seg_mt, seg_mo, seg_st, seg_so  out  7 each  segments {g,f,e,d,c,b,a}, active-high.

## Operation
The control FSM has four states.
- IDLE: wait for key_valid = 1. On that edge, register key_code and go to EVAL.
- EVAL: lasts one cycle and decides the press.
  - Store when load_en = 1, code <= 9 and digit_count < 4. Shift: min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= code. Increment digit_count. Pulse accepted.
  - Otherwise, pulse rejected and change no digits. This covers code 10..15, load_en = 0, and digit_count = 4 (full; no wrap and no overwrite).
  - Then go to HOLD and load the hold counter with HOLDOFF.
- HOLD: decrement the counter each cycle; at 0, go to RELEASE. key_valid is ignored here.
- RELEASE: wait for key_valid = 0, then go to IDLE. A key held for any length therefore yields exactly one press.

Reset and clear behaviour:
- clear_n = 0 sets the state to RELEASE, so a key held through reset is not accepted. It zeroes all digits, digit_count, accepted, rejected and the hold counter.
- entry_clr zeroes the digits and digit_count only; the FSM state is unaffected.
- entry_clr in the same cycle as an EVAL store: clear wins, and the press reports rejected, not accepted.
- load_en is sampled in EVAL only.

7-segment decode:
- 0..9 use standard patterns; for example 0 = 0111111, 1 = 0000110, 8 = 1111111.
- Any other value gives 0000000 (blank).

## Timing
- Reset values: all digit and segment outputs are 0 and 0111111 respectively; digit_count = 0; time_valid, accepted and rejected are 0; the FSM is in RELEASE.
- Latency: key_valid is first sampled high at edge k. EVAL runs in the cycle after k. Digits, digit_count and accepted/rejected update at edge k+1 and are visible for one cycle.
- Segment outputs are combinational from the digit registers and change in the same cycle as the digits.
- Minimum spacing between two stored presses is 1 + HOLDOFF + 1 + 1 cycles. This assumes key_valid is low at the end of HOLD.
- A key_valid bounce during HOLD or RELEASE is never counted.

## Structure
- Shared package microondas_pkg holds:
  - the FSM state typedef (IDLE, EVAL, HOLD, RELEASE, 2-bit);
  - the segment constants SEG_0..SEG_9 and SEG_BLANK;
  - MAX_DIGITS = 4.
- One sub-module, bcd_to_7seg: 4-bit input, 7-bit output, combinational. It is instantiated four times.
- The top level contains the FSM, the hold counter (4 bits), the entry shift register and the digit counter.

## Test plan
- Reset with key_valid held high: release, then press 5. Expect no accept during the held press; after it, sec_ones = 5, digit_count = 1, one accepted pulse.
- Press 1, 2, 3, 0, each held for 40 cycles: expect MM:SS = 12:30, digit_count = 4, time_valid = 1, seg_mt = 0000110. Exactly four accepted pulses.
- With 4 digits stored, press 9: expect one rejected pulse, digits unchanged at 12:30, no wrap.
- Press code 12: expect rejected, digits unchanged. Then press 7 with load_en = 0: expect rejected, digit_count unchanged.
- key_valid pulses high for 2 cycles, low for 1, then high again within HOLDOFF: expect exactly one accepted. Entry 9,0 must give sec_tens = 9, sec_ones = 0, time_valid = 0.
- Drive entry_clr in the EVAL cycle of a press of 4: expect all digits 0, digit_count = 0, rejected = 1, accepted = 0.
- Drive clear_n low mid-HOLD: expect the state machine to return to RELEASE and all outputs to reset values on the next edge.
